// File: rtl/scarv_cop_rng_lfsr.sv
// RNG functional unit for the SCARV coprocessor: Galois LFSR with seed/sample/test ops.
// Optional macro SCARV_COP_RNG_FREE_RUN_EN: LFSR free-runs while idle and not accepting.
//
// state | meaning
// IDLE  | waiting for rng_ivalid; accepts one instruction
// STEP  | SAMP in progress, one LFSR step per cycle
// DONE  | rng_idone pulse cycle, returns to IDLE
module scarv_cop_rng_lfsr #(
    parameter int unsigned                LFSR_WIDTH   = 32,
    parameter logic [LFSR_WIDTH-1:0]      LFSR_TAPS    = 32'h80200003,
    parameter logic [LFSR_WIDTH-1:0]      SEED_DEFAULT = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned                SAMPLE_STEPS = 8
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        rng_ivalid,
    output logic        rng_idone,
    input  logic [31:0] rng_rs1,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_class,
    input  logic [31:0] id_subclass,
    output logic [3:0]  rng_cpr_rd_ben,
    output logic [31:0] rng_cpr_rd_wdata
);

    localparam logic [1:0] SUB_SEED = 2'd0;
    localparam logic [1:0] SUB_SAMP = 2'd1;
    localparam logic [1:0] SUB_TEST = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t                  fsm;
    logic [LFSR_WIDTH-1:0] state;
    logic [LFSR_WIDTH-1:0] state_next;
    logic [LFSR_WIDTH-1:0] seed_mix;
    logic [7:0]            step_cnt;
    logic                  seeded;
    logic                  lockup;
    logic [1:0]            sub;
    logic                  unused_inputs;

    assign unused_inputs = ^{id_imm, id_class, id_subclass[31:2]};
    assign sub           = id_subclass[1:0];

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return {1'b0, s[LFSR_WIDTH-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    assign state_next = lfsr_step(state);
    assign seed_mix   = state ^ LFSR_WIDTH'(rng_rs1);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            fsm              <= IDLE;
            state            <= SEED_DEFAULT;
            step_cnt         <= 8'd0;
            seeded           <= 1'b0;
            lockup           <= 1'b0;
            rng_idone        <= 1'b0;
            rng_cpr_rd_ben   <= 4'h0;
            rng_cpr_rd_wdata <= 32'h0;
        end else begin
            rng_idone        <= 1'b0;
            rng_cpr_rd_ben   <= 4'h0;
            rng_cpr_rd_wdata <= 32'h0;
            case (fsm)
                IDLE: begin
                    if (rng_ivalid) begin
                        case (sub)
                            SUB_SEED: begin
                                seeded    <= 1'b1;
                                // An all-zero state would lock the LFSR forever.
                                if (seed_mix == '0) begin
                                    state  <= SEED_DEFAULT;
                                    lockup <= 1'b1;
                                end else begin
                                    state  <= seed_mix;
                                end
                                rng_idone <= 1'b1;
                                fsm       <= DONE;
                            end
                            SUB_SAMP: begin
                                step_cnt <= 8'(SAMPLE_STEPS - 1);
                                fsm      <= STEP;
                            end
                            SUB_TEST: begin
                                rng_idone        <= 1'b1;
                                rng_cpr_rd_ben   <= 4'hF;
                                rng_cpr_rd_wdata <= {30'b0, lockup, seeded};
                                fsm              <= DONE;
                            end
                            default: begin
                                rng_idone        <= 1'b1;
                                rng_cpr_rd_wdata <= {30'b0, lockup, seeded};
                                fsm              <= DONE;
                            end
                        endcase
                    end
`ifdef SCARV_COP_RNG_FREE_RUN_EN
                    else begin
                        state <= state_next;
                    end
`endif
                end
                STEP: begin
                    state    <= state_next;
                    step_cnt <= step_cnt - 8'd1;
                    if (step_cnt == 8'd0) begin
                        rng_idone        <= 1'b1;
                        rng_cpr_rd_ben   <= 4'hF;
                        rng_cpr_rd_wdata <= state_next[31:0];
                        fsm              <= DONE;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_cop_rng_lfsr.sv
// Directed scoreboard bench for scarv_cop_rng_lfsr (default and SAMPLE_STEPS=1 instances).
module tb_scarv_cop_rng_lfsr;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        rng_ivalid = 1'b0;
    logic [31:0] rng_rs1 = 32'h0;
    logic [31:0] id_imm = 32'h0;
    logic [31:0] id_class = 32'h0;
    logic [31:0] id_subclass = 32'h0;
    logic        sel = 1'b0;

    logic        idone_a, idone_b;
    logic [3:0]  ben_a, ben_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ivalid_a, ivalid_b;

    assign ivalid_a = rng_ivalid & ~sel;
    assign ivalid_b = rng_ivalid & sel;

    scarv_cop_rng_lfsr dut_a (
        .g_clk(g_clk), .g_reset(g_reset), .rng_ivalid(ivalid_a), .rng_idone(idone_a),
        .rng_rs1(rng_rs1), .id_imm(id_imm), .id_class(id_class), .id_subclass(id_subclass),
        .rng_cpr_rd_ben(ben_a), .rng_cpr_rd_wdata(wdata_a)
    );

    scarv_cop_rng_lfsr #(.SAMPLE_STEPS(1)) dut_b (
        .g_clk(g_clk), .g_reset(g_reset), .rng_ivalid(ivalid_b), .rng_idone(idone_b),
        .rng_rs1(rng_rs1), .id_imm(id_imm), .id_class(id_class), .id_subclass(id_subclass),
        .rng_cpr_rd_ben(ben_b), .rng_cpr_rd_wdata(wdata_b)
    );

    always #5 g_clk = ~g_clk;

    wire        idone = sel ? idone_b : idone_a;
    wire [3:0]  ben   = sel ? ben_b   : ben_a;
    wire [31:0] wdata = sel ? wdata_b : wdata_a;

    typedef struct {
        int          lat;
        logic [3:0]  ben;
        logic [31:0] wdata;
        bit          chk_w;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_state;
    logic        m_seeded, m_lockup;

`ifdef SCARV_COP_RNG_FREE_RUN_EN
    localparam bit FREE_RUN = 1'b1;
`else
    localparam bit FREE_RUN = 1'b0;
`endif

    function automatic logic [31:0] step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_idone"}, 64'(idone), 64'd0);
        check({tag, "_out"}, {28'd0, ben, wdata}, 64'd0);
    endtask

    task automatic do_reset();
        g_reset    = 1'b1;
        rng_ivalid = 1'b0;
        repeat (2) begin
            @(posedge g_clk); #1;
            check_quiet("reset");
        end
        g_reset  = 1'b0;
        m_state  = 32'h1;
        m_seeded = 1'b0;
        m_lockup = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sub, input logic [31:0] rs1, input int gap);
        exp_t e;
        int   lat;
        int   nsteps;
        repeat (gap) begin
            @(posedge g_clk); #1;
            check_quiet("idle");
            if (FREE_RUN) m_state = step(m_state);
        end
        nsteps  = sel ? 1 : 8;
        e.ben   = 4'h0;
        e.wdata = 32'h0;
        e.chk_w = 1'b1;
        case (sub)
            2'd0: begin
                m_state  = m_state ^ rs1;
                m_seeded = 1'b1;
                if (m_state == 32'h0) begin
                    m_state  = 32'h1;
                    m_lockup = 1'b1;
                end
                e.lat = 1;
            end
            2'd1: begin
                for (int i = 0; i < nsteps; i++) m_state = step(m_state);
                e.lat   = nsteps + 1;
                e.ben   = 4'hF;
                e.wdata = m_state;
            end
            2'd2: begin
                e.lat   = 1;
                e.ben   = 4'hF;
                e.wdata = {30'b0, m_lockup, m_seeded};
            end
            default: begin
                e.lat   = 1;
                e.chk_w = 1'b0;
            end
        endcase
        sb.push_back(e);
        rng_ivalid  = 1'b1;
        id_subclass = {30'h0, sub};
        rng_rs1     = rs1;
        lat = 0;
        do begin
            @(posedge g_clk); #1;
            lat++;
            // Operands after the accept edge must be ignored.
            rng_rs1     = ~rs1;
            id_subclass = {30'h0, ~sub};
            if (!idone) check_quiet("busy");
        end while (!idone && lat < 60);
        if (!idone) begin
            check("timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("latency", 64'(lat), 64'(e.lat));
            check("ben", 64'(ben), 64'(e.ben));
            if (e.chk_w) check("wdata", 64'(wdata), 64'(e.wdata));
        end
        @(posedge g_clk); #1;
        check_quiet("after_done");
        rng_ivalid = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        // 1: TEST straight out of reset
        issue(2'd2, 32'h0, 0);
        // 2: SEED that cancels to zero recovers and flags lockup
        do_reset();
        issue(2'd0, 32'h1, 0);
        issue(2'd2, 32'h0, 2);
        // 3: single-step sampler
        sel = 1'b1;
        do_reset();
        issue(2'd1, 32'h0, 0);
        issue(2'd1, 32'h0, 0);
        sel = 1'b0;
        // 4: full SAMP latency, single pulse with ivalid held
        do_reset();
        issue(2'd1, 32'h1234, 3);
        // 5: reset three cycles into a SAMP
        rng_ivalid  = 1'b1;
        id_subclass = 32'd1;
        repeat (3) begin
            @(posedge g_clk); #1;
            check_quiet("pre_abort");
        end
        do_reset();
        repeat (3) begin
            @(posedge g_clk); #1;
            check_quiet("post_abort");
            if (FREE_RUN) m_state = step(m_state);
        end
        issue(2'd2, 32'h0, 0);
        issue(2'd1, 32'h0, 1);
        // 6: nonzero seed, reserved subclass, two samples 5 idle cycles apart
        issue(2'd0, 32'hDEADBEEF, 0);
        issue(2'd2, 32'h0, 0);
        issue(2'd3, 32'h0, 2);
        issue(2'd1, 32'h0, 0);
        issue(2'd1, 32'h0, 5);
        issue(2'd2, 32'h0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scarv_cop_rng_lfsr.md
Name: scarv_cop_rng_lfsr

Overview:
Parametrised pseudo-random number unit for the SCARV crypto coprocessor. It executes the RNG instruction class: seed, sample and test. It holds a Galois LFSR state register of configurable width, with a multi-cycle sampling FSM and a status register. It sits beside the other cop functional units, sharing the ivalid/idone issue handshake and CPR writeback path.

Parameters:
LFSR_WIDTH, 32, state width in bits; legal range 32..64.
LFSR_TAPS, 32'h80200003, Galois feedback mask, LFSR_WIDTH bits.
SEED_DEFAULT, 1, reset and lockup-recovery state; must be nonzero.
SAMPLE_STEPS, 8, LFSR steps per sample; legal range 1..255.

Ports:
g_clk  input  1  clock; all state updates on rising edge.
g_reset  input  1  synchronous, active-high reset.
rng_ivalid  input  1  valid RNG instruction; held high until rng_idone.
rng_idone  output  1  one-cycle pulse: instruction complete.
rng_rs1  input  32  source register 1 (seed material).
id_imm  input  32  decoded immediate; unused, reserved.
id_class  input  32  decoded class; unused, gating done upstream.
id_subclass  input  32  bits [1:0]: 0=SEED, 1=SAMP, 2=TEST, 3=reserved.
rng_cpr_rd_ben  output  4  writeback byte enable; valid with rng_idone.
rng_cpr_rd_wdata  output  32  writeback data; valid with rng_idone.

Behaviour:
- Step function: next = {1'b0, s[W-1:1]} ^ (s[0] ? LFSR_TAPS : 0).
- Reset: state=SEED_DEFAULT; seeded=0; lockup=0; FSM=IDLE.
- Outputs are 0 while in reset and on every cycle that rng_idone=0, including ben and wdata.
- FSM states: IDLE, STEP, DONE.
- IDLE -> DONE when rng_ivalid and subclass is SEED, TEST or reserved. The action occurs on the accept edge.
- IDLE -> STEP when rng_ivalid and subclass is SAMP. Step counter loads SAMPLE_STEPS-1.
- STEP: one LFSR step per cycle. The counter decrements each cycle. Exit to DONE on the cycle the counter is 0, after that cycle's step.
- DONE: rng_idone=1 for exactly one cycle, then IDLE. An instruction still showing ivalid in that cycle is not re-accepted; acceptance needs IDLE.
- Latency from the accept edge to the idone cycle:
  - SEED, TEST and reserved: 1 cycle.
  - SAMP: SAMPLE_STEPS+1 cycles.
- SEED:
  - state ^= zero-extended rng_rs1; seeded=1.
  - If the XOR result is 0, state=SEED_DEFAULT and lockup=1.
  - Completion: ben=4'h0, wdata=0.
- SAMP: ben=4'hF; wdata = state[31:0] after the final step.
- TEST: ben=4'hF; wdata = {30'b0, lockup, seeded}. Both flags are sticky until reset.
- Reserved subclass: completes like TEST but ben=4'h0, so there is no writeback.
- Operand sampling: rng_rs1 and id_subclass are sampled only on the accept edge. Changes afterwards have no effect.
- Reset mid-operation, in STEP or DONE: returns to IDLE with no idone pulse, and all state reverts to reset values.
- The state register never holds zero. An all-zero state is reachable only via SEED, and that case is covered by the recovery rule above.

Optional Feature:
SCARV_COP_RNG_FREE_RUN_EN:
- Defined: the LFSR also steps once every cycle while FSM=IDLE and no instruction is accepted. This decorrelates samples from issue timing. On the accept edge of SEED the XOR applies to the current state with no extra step in that cycle.
- Undefined: the state changes only via SEED, SAMP steps, or reset. Sample sequences are fully deterministic per instruction stream.

Test Plan:
All scenarios use default parameters and free-run undefined unless stated.
1. Reset, then TEST -> idone 1 cycle after accept; ben=F, wdata=0x00000000.
2. Reset; SEED rs1=0x00000001 -> XOR=0, state restored to 0x1; then TEST -> wdata=0x00000003.
3. SAMPLE_STEPS=1; reset; SAMP -> idone 2 cycles after accept, wdata=0x80200003. A second SAMP -> wdata=0xC0300002.
4. Default SAMPLE_STEPS=8; SAMP -> idone exactly 9 cycles after accept; ivalid held throughout. Single pulse, and no re-issue while ivalid stays high in the DONE cycle.
5. Assert g_reset 3 cycles into a SAMP -> no idone; then TEST -> 0x00000000; SAMP result matches the scenario-3 reference model from SEED_DEFAULT.
6. SEED rs1=0xDEADBEEF -> ben=0, no lockup. Subclass 3 -> idone after 1 cycle with ben=0. Free-run defined: two SAMPs separated by 5 idle cycles -> results match a model stepping 5 extra times.
